spi_slave: RTL and testbench
============================

# spi_slave

Serial front end for the SPI memory subsystem. Deserialises MOSI frames into 10-bit command/data words for the RAM block (`rx_data`/`rx_valid`), and serialises the RAM's read byte (`tx_data`/`tx_valid`) back onto MISO. Sits between the external SPI master and the RAM inside the SPI wrapper. `clk` is the SPI serial clock.

## Interface
- `FRAME_W`, 10: frame width; 2 command bits plus 8 address/data bits.
- `DATA_W`, 8: read-data width shifted out on MISO.

- `clk`  in  1  SPI clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `SS_n`  in  1  slave select, active low.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first.
- `rx_data`  out  FRAME_W  assembled frame {cmd[1:0], payload[7:0]} to RAM.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` is valid.
- `tx_data`  in  DATA_W  read byte from RAM.
- `tx_valid`  in  1  `tx_data` valid; sampled only while awaiting read data.

## Operation
- Reset values:
  - `MISO`=0, `rx_data`=0, `rx_valid`=0.
  - state=IDLE, bit counter=0, `rd_addr_done`=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: `SS_n`=0 → CHK_CMD. Otherwise stay.
- CHK_CMD:
  - Samples the first frame bit (`rx_data[9]`) into the shift register; counter=1.
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_done`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_done`=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift one MOSI bit per edge until 10 bits are held, then:
  - Register `rx_data` and pulse `rx_valid` for exactly one cycle.
  - READ_ADD frame complete: set `rd_addr_done`.
  - READ_DATA frame complete: clear `rd_addr_done`; wait for `tx_valid`.
- Bits 9:8 are passed through unmodified; the RAM decodes the command. The state choice only affects MISO behaviour and `rd_addr_done`.
- READ_DATA, after the frame:
  - First edge with `tx_valid`=1: capture `tx_data` and drive `MISO`=`tx_data[7]`.
  - Next 7 edges: bits 6..0.
  - Then `MISO`=0. Further `tx_valid` pulses are ignored until the next READ_DATA frame.
- `SS_n`=1 in any state:
  - Next state is IDLE; counter and tx shift are cleared; `MISO`=0.
  - A partial frame produces no `rx_valid`.
  - `rd_addr_done` is retained.
- A frame completing in WRITE or READ_ADD never drives MISO; it stays 0.

## Timing
- Edge 0: `SS_n` sampled low, IDLE→CHK_CMD.
- Edge 1: bit 9 sampled.
- Edges 2..10: bits 8..0 sampled.
- Edge 10: `rx_valid` rises and `rx_data` is updated. Edge 11: `rx_valid` falls.
- Read latency: the RAM asserts `tx_valid` combinationally during the `rx_valid` cycle, so it is sampled at edge 11.
  - `MISO` carries bits 7..0 after edges 11..18.
  - The master samples MISO on the falling edge after each of those edges.
- Minimum `SS_n` low time: 11 edges for write/address frames; 19 edges for read-data frames.
- `reset` asserted mid-frame: all outputs return to reset values immediately; `rd_addr_done` clears.
- Back-to-back frames: `SS_n` must be high for at least one edge; the slave then re-enters via IDLE.

## Structure
- Shared package `spi_pkg`:
  - State enum `spi_state_t`.
  - Constants `FRAME_W`=10, `DATA_W`=8.
  - Command codes: `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
- One sub-module: `spi_tx_serializer`, an 8-bit load/shift register with bit counter. Ports: load, data, shift-enable, clear; output MISO.
- The top-level wrapper instantiates `spi_slave` and the RAM, connecting `rx_data`→`din`, `rx_valid`, `dout`→`tx_data` and `tx_valid`.

## Test plan
- Write address: `SS_n` low, MOSI 00_0000_0101 → `rx_valid` pulse at edge 10 with `rx_data`=10'h005; MISO stays 0; `rd_addr_done`=0.
- Write data: frame 01_1010_0101 → `rx_data`=10'h1A5, single-cycle `rx_valid`.
- Read address then read data:
  - Frame 10_0000_0101 → `rx_data`=10'h205; `rd_addr_done`=1.
  - Next frame 11_xxxx_xxxx with `tx_data`=8'hA5 and `tx_valid` at edge 11 → MISO sequence 1,0,1,0,0,1,0,1 on edges 11..18; `rd_addr_done`=0.
- Abort: `SS_n` raised after 6 bits → no `rx_valid`; IDLE next edge; a following full frame decodes correctly.
- Reset mid-transfer: assert `reset` during MISO shifting → MISO=0, `rx_valid`=0, state IDLE, `rd_addr_done`=0 immediately.
- Spurious `tx_valid` during WRITE and READ_ADD frames → MISO remains 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_t;

  // The first frame bit alone tells write frames from read frames.
  function automatic logic is_read_cmd(input logic cmd_msb);
    return cmd_msb == CMD_RD_ADDR[1];
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first load/shift register driving MISO; idles at 0 once all bits are out.
module spi_tx_serializer
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              shift_en,
  input  logic              clear,
  output logic              miso
);

  localparam int LEFT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sh_q,   sh_d;
  logic [LEFT_W-1:0] left_q, left_d;
  logic              miso_q, miso_d;

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    sh_d   = sh_q;
    left_d = left_q;
    miso_d = miso_q;
    if (clear) begin
      sh_d   = '0;
      left_d = '0;
      miso_d = 1'b0;
    end else if (load) begin
      miso_d = data[DATA_W-1];
      sh_d   = {data[DATA_W-2:0], 1'b0};
      left_d = LEFT_W'(DATA_W - 1);
    end else if (shift_en) begin
      if (left_q != '0) begin
        miso_d = sh_q[DATA_W-1];
        sh_d   = {sh_q[DATA_W-2:0], 1'b0};
        left_d = left_q - 1'b1;
      end else begin
        miso_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q   <= '0;
      left_q <= '0;
      miso_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      left_q <= left_d;
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: deserialises 10-bit MOSI frames for the RAM and returns read bytes on MISO.
module spi_slave
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);

  spi_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_done_q, rd_addr_done_d;
  logic               tx_loaded_q, tx_loaded_d;
  logic               tx_load, tx_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      tx_loaded_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      tx_loaded_q    <= tx_loaded_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CHK_CMD;
        CHK_CMD: begin
          if (!is_read_cmd(MOSI))  state_d = WRITE;
          else if (rd_addr_done_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    tx_loaded_d    = tx_loaded_q;
    tx_load        = 1'b0;
    tx_shift       = 1'b0;
    if (SS_n) begin
      // Deselect abandons any partial frame but keeps the read-address history.
      cnt_d       = '0;
      shift_d     = '0;
      tx_loaded_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: cnt_d = '0;
        CHK_CMD: begin
          shift_d = {{(FRAME_W-1){1'b0}}, MOSI};
          cnt_d   = CNT_W'(1);
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (cnt_q != FRAME_CNT) begin
            shift_d = {shift_q[FRAME_W-2:0], MOSI};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              rx_data_d  = shift_d;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)  rd_addr_done_d = 1'b1;
              if (state_q == READ_DATA) rd_addr_done_d = 1'b0;
            end
          end else if (state_q == READ_DATA) begin
            if (tx_loaded_q) begin
              tx_shift = 1'b1;
            end else if (tx_valid) begin
              tx_load     = 1'b1;
              tx_loaded_d = 1'b1;
            end
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  spi_tx_serializer u_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_load),
    .data     (tx_data),
    .shift_en (tx_shift),
    .clear    (SS_n),
    .miso     (MISO)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write, read-address/read-data, abort and reset cases.
module tb_spi_slave;
  import spi_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  int n_cmp = 0;
  int n_mis = 0;

  spi_slave dut (
    .clk      (clk),
    .reset    (reset),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges 0..10 of a frame; SS_n is left low so the caller controls what follows.
  task automatic send_frame(input logic [FRAME_W-1:0] f, input string tag);
    SS_n = 1'b0;
    tick();
    check({tag, "_chk_state"}, 32'(dut.state_q), 32'(CHK_CMD));
    for (int i = FRAME_W - 1; i >= 0; i--) begin
      MOSI = f[i];
      tick();
      check({tag, "_miso_in_frame"}, 32'(MISO), 32'd0);
      if (i != 0) check({tag, "_no_early_valid"}, 32'(rx_valid), 32'd0);
    end
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_rx_data"}, 32'(rx_data), 32'(f));
  endtask

  task automatic end_frame(input string tag);
    SS_n = 1'b1;
    tick();
    check({tag, "_idle"}, 32'(dut.state_q), 32'(IDLE));
    check({tag, "_miso_idle"}, 32'(MISO), 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd_byte;
    reset = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    #2;
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_rd_addr_done", 32'(dut.rd_addr_done_q), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Write address with a spurious tx_valid held high throughout.
    tx_valid = 1'b1; tx_data = 8'hFF;
    send_frame(10'h005, "wr_addr");
    tick();
    check("wr_addr_valid_fall", 32'(rx_valid), 32'd0);
    check("wr_addr_miso_after", 32'(MISO), 32'd0);
    tick();
    check("wr_addr_miso_after2", 32'(MISO), 32'd0);
    check("wr_addr_rd_done", 32'(dut.rd_addr_done_q), 32'd0);
    end_frame("wr_addr");
    tx_valid = 1'b0;

    send_frame(10'h1A5, "wr_data");
    tick();
    check("wr_data_single_cycle", 32'(rx_valid), 32'd0);
    end_frame("wr_data");

    // Read address, again with spurious tx_valid.
    tx_valid = 1'b1;
    send_frame(10'h205, "rd_addr");
    check("rd_addr_done_set", 32'(dut.rd_addr_done_q), 32'd1);
    tick();
    check("rd_addr_miso_after", 32'(MISO), 32'd0);
    tick();
    check("rd_addr_miso_after2", 32'(MISO), 32'd0);
    end_frame("rd_addr");
    tx_valid = 1'b0;
    check("rd_addr_done_kept", 32'(dut.rd_addr_done_q), 32'd1);

    // Read data: RAM presents A5 during the rx_valid cycle, sampled at edge 11.
    send_frame(10'h3C3, "rd_data");
    check("rd_data_done_clr", 32'(dut.rd_addr_done_q), 32'd0);
    tx_data = 8'hA5; tx_valid = 1'b1;
    rd_byte = 8'hA5;
    tick();
    check("rd_data_valid_fall", 32'(rx_valid), 32'd0);
    check("rd_miso_b7", 32'(MISO), 32'(rd_byte[7]));
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int b = 6; b >= 0; b--) begin
      tick();
      check($sformatf("rd_miso_b%0d", b), 32'(MISO), 32'(rd_byte[b]));
    end
    tick();
    check("rd_miso_tail", 32'(MISO), 32'd0);
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    check("rd_late_tx_valid_ignored", 32'(MISO), 32'd0);
    tx_valid = 1'b0;
    end_frame("rd_data");

    // Fresh read address, then abort a read-data frame after 6 bits.
    send_frame(10'h2AA, "rd_addr2");
    end_frame("rd_addr2");
    SS_n = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      MOSI = (i < 2) ? 1'b1 : i[0];
      tick();
      check("abort_no_valid", 32'(rx_valid), 32'd0);
    end
    SS_n = 1'b1;
    tick();
    check("abort_idle", 32'(dut.state_q), 32'(IDLE));
    check("abort_rx_valid", 32'(rx_valid), 32'd0);
    check("abort_rd_done_kept", 32'(dut.rd_addr_done_q), 32'd1);
    check("abort_cnt_clr", 32'(dut.cnt_q), 32'd0);
    tick();
    check("abort_rx_valid2", 32'(rx_valid), 32'd0);
    send_frame(10'h1F0, "post_abort");
    end_frame("post_abort");

    // Reset while MISO is shifting a read byte.
    send_frame(10'h300, "rst_rd");
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    check("rst_rd_b7", 32'(MISO), 32'd1);
    tx_valid = 1'b0;
    tick();
    check("rst_rd_b6", 32'(MISO), 32'd0);
    tick();
    check("rst_rd_b5", 32'(MISO), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_miso", 32'(MISO), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    check("midrst_rd_done", 32'(dut.rd_addr_done_q), 32'd0);
    SS_n = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(dut.state_q), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
